// File: rtl/decode_pkg.sv
// Shared types and decode helpers for the instruction decode stage.
package decode_pkg;

   localparam int unsigned INSTR_W = 9;
   localparam int unsigned ADDR_W  = 3;
   localparam int unsigned DATA_W  = 8;

   typedef enum logic [2:0] {
      OP_ADD     = 3'd0,
      OP_SUB     = 3'd1,
      OP_AND     = 3'd2,
      OP_LDR     = 3'd3,
      OP_STR     = 3'd4,
      OP_LIM     = 3'd5,
      OP_BNZ     = 3'd6,
      OP_SPECIAL = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_AND  = 2'b10,
      ALU_PASS = 2'b11
   } aluop_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   localparam logic [5:0] HALT_CODE = 6'h3F;

   typedef struct packed {
      logic [ADDR_W-1:0] reg1;
      logic [ADDR_W-1:0] reg2;
      logic [ADDR_W-1:0] wReg;
      logic              writeReg;
      logic [DATA_W-1:0] imm;
      aluop_t            aluOp;
      logic              memRead;
      logic              memWrite;
      logic              isBranch;
      logic              decValid;
   } ctrl_t;

   localparam ctrl_t BUBBLE = ctrl_t'('0);

   // Decode one instruction into its control word; unused fields stay zero.
   function automatic ctrl_t decodeInstr(input logic [INSTR_W-1:0] instr);
      ctrl_t c;
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
      c = BUBBLE;
      a = instr[5:3];
      b = instr[2:0];
      c.decValid = 1'b1;
      case (opcode_t'(instr[8:6]))
         OP_ADD: begin c.reg1 = a; c.reg2 = b; c.wReg = a; c.writeReg = 1'b1; c.aluOp = ALU_ADD; end
         OP_SUB: begin c.reg1 = a; c.reg2 = b; c.wReg = a; c.writeReg = 1'b1; c.aluOp = ALU_SUB; end
         OP_AND: begin c.reg1 = a; c.reg2 = b; c.wReg = a; c.writeReg = 1'b1; c.aluOp = ALU_AND; end
         OP_LDR: begin c.wReg = a; c.reg2 = b; c.memRead = 1'b1; c.writeReg = 1'b1; end
         OP_STR: begin c.reg1 = a; c.reg2 = b; c.memWrite = 1'b1; end
         OP_LIM: begin c.imm = {2'b00, instr[5:0]}; c.aluOp = ALU_PASS; c.writeReg = 1'b1; end
         OP_BNZ: begin c.reg1 = a; c.isBranch = 1'b1; c.imm = {5'b00000, b}; end
         default: ;
      endcase
      return c;
   endfunction

   // Bit 0: field a is a source; bit 1: field b is a source.
   function automatic logic [1:0] sourceMask(input logic [INSTR_W-1:0] instr);
      logic [1:0] m;
      case (opcode_t'(instr[8:6]))
         OP_ADD, OP_SUB, OP_AND, OP_STR: m = 2'b11;
         OP_LDR:                         m = 2'b10;
         OP_BNZ:                         m = 2'b01;
         default:                        m = 2'b00;
      endcase
      return m;
   endfunction

   function automatic logic isHalt(input logic [INSTR_W-1:0] instr);
      return (opcode_t'(instr[8:6]) == OP_SPECIAL) && (instr[5:0] == HALT_CODE);
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection against the load currently held in the decode register.
module hazard_unit #(
   parameter int unsigned DT = 3
) (
   input  logic [DT-1:0] srcA,
   input  logic [DT-1:0] srcB,
   input  logic [1:0]    srcMask,
   input  logic [DT-1:0] wRegQ,
   input  logic          memReadQ,
   input  logic          decValidQ,
   output logic          hazard
);

   // Hazard only when a used source reads the register the pending load writes.
   always_comb begin
      hazard = decValidQ && memReadQ &&
               ((srcMask[0] && (srcA == wRegQ)) || (srcMask[1] && (srcB == wRegQ)));
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: handshake with fetch, registered regFile/ALU/memory
// controls, load-use bubbling, flush and sticky HALT.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned IW = INSTR_W,
   parameter int unsigned DT = ADDR_W,
   parameter int unsigned WT = DATA_W
) (
   input  logic          CLK,
   input  logic          Reset_n,
   input  logic [IW-1:0] InstrIn,
   input  logic          InstrValid,
   output logic          InstrReady,
   input  logic          Flush,
   output logic [DT-1:0] Reg1,
   output logic [DT-1:0] Reg2,
   output logic [DT-1:0] WReg,
   output logic          WriteReg,
   output logic [WT-1:0] Imm,
   output logic [1:0]    AluOp,
   output logic          MemRead,
   output logic          MemWrite,
   output logic          IsBranch,
   output logic          DecValid,
   output logic          Halted
);

   state_t     state;
   state_t     stateNext;
   ctrl_t      ctrlQ;
   ctrl_t      ctrlNext;
   ctrl_t      ctrlDec;
   logic [1:0] srcMask;
   logic       hazard;
   logic       accept;

   assign ctrlDec = decodeInstr(InstrIn);
   assign srcMask = sourceMask(InstrIn);

   hazard_unit #(.DT(DT)) uHazard (
      .srcA      (InstrIn[5:3]),
      .srcB      (InstrIn[2:0]),
      .srcMask   (srcMask),
      .wRegQ     (ctrlQ.wReg),
      .memReadQ  (ctrlQ.memRead),
      .decValidQ (ctrlQ.decValid),
      .hazard    (hazard)
   );

   // Handshake, next state and next control word; anything not accepted becomes a bubble.
   always_comb begin
      stateNext  = state;
      ctrlNext   = BUBBLE;
      InstrReady = (state == ST_RUN) && !Flush && !hazard;
      accept     = InstrReady && InstrValid;
      if (accept) begin
         if (isHalt(InstrIn)) begin
            stateNext = ST_HALT;
         end else begin
            ctrlNext = ctrlDec;
         end
      end
   end

   // State and control registers.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_RUN;
         ctrlQ <= BUBBLE;
      end else begin
         state <= stateNext;
         ctrlQ <= ctrlNext;
      end
   end

   assign Reg1     = ctrlQ.reg1;
   assign Reg2     = ctrlQ.reg2;
   assign WReg     = ctrlQ.wReg;
   assign WriteReg = ctrlQ.writeReg;
   assign Imm      = ctrlQ.imm;
   assign AluOp    = ctrlQ.aluOp;
   assign MemRead  = ctrlQ.memRead;
   assign MemWrite = ctrlQ.memWrite;
   assign IsBranch = ctrlQ.isBranch;
   assign DecValid = ctrlQ.decValid;
   assign Halted   = (state == ST_HALT);

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage, directly upstream of regFile.
- Accepts 9-bit instructions from fetch via a valid/ready handshake.
- Produces registered regFile control (Reg1, Reg2, WReg, WriteReg) plus ALU and memory controls for the execute stage.
- Owns load-use hazard bubbling, pipeline flush on taken branch, and the HALT state.

Parameters:
- IW, 9, instruction width
- DT, 3, register-address width (matches regFile D)
- WT, 8, data/immediate width (matches regFile W)

Ports:
- CLK  in  1  system clock, rising-edge
- Reset_n  in  1  asynchronous active-low reset
- InstrIn  in  IW  instruction from fetch
- InstrValid  in  1  InstrIn valid
- InstrReady  out  1  stage accepts InstrIn this cycle (combinational)
- Flush  in  1  taken branch from execute; kill in-flight work
- Reg1  out  DT  regFile read address 1
- Reg2  out  DT  regFile read address 2
- WReg  out  DT  regFile write address
- WriteReg  out  1  regFile write enable
- Imm  out  WT  zero-extended immediate
- AluOp  out  2  00 add, 01 sub, 10 and, 11 pass-immediate
- MemRead  out  1  load
- MemWrite  out  1  store
- IsBranch  out  1  branch-if-nonzero on Reg1
- DecValid  out  1  registered outputs hold a real instruction
- Halted  out  1  HALT decoded; stage frozen

Behaviour:
- Reset (async, Reset_n=0): all registered outputs 0; state RUN; Halted=0. InstrReady=1 once Reset_n=1 and no hazard.
- Encoding: op=InstrIn[8:6], a=[5:3], b=[2:0].
  - 000 ADD, 001 SUB, 010 AND: Reg1=a, Reg2=b, WReg=a, WriteReg=1. Sources a,b.
  - 011 LDR: WReg=a, Reg2=b, MemRead=1, WriteReg=1, AluOp=00. Source b.
  - 100 STR: Reg1=a, Reg2=b, MemWrite=1, WriteReg=0. Sources a,b.
  - 101 LIM: Imm={2'b0,InstrIn[5:0]}, WReg=0, Reg1=0, AluOp=11, WriteReg=1. No sources.
  - 110 BNZ: Reg1=a, IsBranch=1, Imm={5'b0,b}. Source a.
  - 111: [5:0]=6'h3F is HALT; else NOP (DecValid=1, all enables 0).
- Unused address fields drive 0.
- Latency: 1 cycle. An instruction is accepted on an edge where InstrValid && InstrReady; its decode appears on outputs after that edge.
- Bubble (all register loads on a no-accept edge): DecValid, WriteReg, MemRead, MemWrite, IsBranch = 0; Reg1/Reg2/WReg/Imm/AluOp = 0.
- Hazard (combinational):
  - Asserts when DecValid && MemRead && a source of InstrIn equals WReg.
  - Applies only to sources the opcode actually uses.
  - Effect: InstrReady=0 and a bubble is registered.
  - Exactly one bubble per load, since the bubble clears MemRead.
- InstrReady = (state==RUN) && !Flush && !hazard.
- Flush:
  - Next edge registers a bubble; InstrIn that cycle is not accepted.
  - Flush wins over hazard and over an incoming HALT.
  - Flush in HALT has no effect.
- FSM:
  - RUN -> HALT on acceptance of HALT. HALT registers a bubble and sets Halted=1.
  - HALT is sticky until Reset_n: InstrReady=0, outputs hold bubble.
- InstrValid=0 in RUN: bubble registered.
- Reset mid-stall or mid-flush: immediate return to reset values; no pending bubble survives.

Decomposition:
- decode_pkg:
  - opcode_t enum (ADD..SPECIAL)
  - aluop_t enum
  - HALT_CODE = 6'h3F
  - decoded-control struct (Reg1..IsBranch) and BUBBLE constant
  - function decoding an instruction into that struct, plus its source mask.
- Sub-module hazard_unit (combinational): inputs are the incoming source addresses/mask and the registered WReg/MemRead/DecValid; output is the hazard flag.

Test Plan:
- Reset: assert Reset_n=0 mid-run with DecValid=1 -> all outputs 0, Halted=0 immediately; after release InstrReady=1.
- ADD: InstrIn=9'b000_001_010 valid -> next edge Reg1=1, Reg2=2, WReg=1, WriteReg=1, AluOp=00, DecValid=1; then feed into regFile with WriteValue=8'hFE -> R1 reads 8'hFE.
- LIM: InstrIn=9'b101_101010 -> Imm=8'h2A, WReg=0, Reg1=0, AluOp=11, WriteReg=1.
- Load-use with LDR r3,(r4)=9'b011_011_100:
  - Followed by ADD r3,r1=9'b000_011_001 -> InstrReady=0 for one cycle, one bubble, ADD decoded one cycle later.
  - Followed by ADD r5,r6 instead -> no bubble.
- Flush in the same cycle as valid ADD -> InstrReady=0, next edge DecValid=0, WriteReg=0; ADD is accepted the following cycle when Flush=0.
- HALT/NOP:
  - 9'b111_111111 -> Halted=1 next edge, InstrReady stays 0, later valid ADD is ignored.
  - HALT with Flush=1 -> stays RUN.
  - 9'b111_000000 -> DecValid=1, all enables 0.
